// File: rtl/store_rmw_sequencer.sv
// Multicycle store sequencer: sw writes directly; sh/sb read the word,
// capture it in the MDR, merge the low half/byte and write it back.
module store_rmw_sequencer #(
    parameter int READ_LATENCY = 1,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  SScontrol,
    input  logic [31:0] addr,
    input  logic [31:0] B_output,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] MemDataReg_out,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_CAPTURE,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_SW  = 2'b01;
    localparam logic [1:0] OP_SH  = 2'b10;
    localparam logic [1:0] OP_SB  = 2'b11;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        b_q, b_d;
    logic [31:0]        mdr_q, mdr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               misaligned;
    logic [31:0]        merged;

    assign misaligned = ((SScontrol == OP_SW) && (addr[1:0] != 2'b00)) ||
                        ((SScontrol == OP_SH) && addr[0]);

    always_comb begin
        merged = b_q;
        unique case (op_q)
            OP_SH:   merged = {mdr_q[31:16], b_q[15:0]};
            OP_SB:   merged = {mdr_q[31:8], b_q[7:0]};
            default: merged = b_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        b_d     = b_q;
        mdr_d   = mdr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = SScontrol;
                    addr_d = addr;
                    b_d    = B_output;
                    if (misaligned)
                        state_d = S_ERR;
                    else if (SScontrol == OP_NOP)
                        state_d = S_DONE;
                    else if (SScontrol == OP_SW)
                        state_d = S_WRITE;
                    else
                        state_d = S_READ;
                end
            end
            S_READ: begin
                cnt_d   = CNT_W'(READ_LATENCY - 1);
                state_d = (READ_LATENCY == 1) ? S_CAPTURE : S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1))
                    state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                mdr_d   = mem_rdata;
                state_d = S_WRITE;
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            b_q     <= '0;
            mdr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            b_q     <= b_d;
            mdr_q   <= mdr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore outputs: everything below depends on registered state only
    assign busy           = (state_q == S_READ) || (state_q == S_WAIT) ||
                            (state_q == S_CAPTURE) || (state_q == S_WRITE);
    assign mem_rd         = (state_q == S_READ);
    assign mem_wr         = (state_q == S_WRITE);
    assign done           = (state_q == S_DONE);
    assign err            = (state_q == S_ERR);
    assign mem_addr       = busy ? addr_q : 32'h0;
    assign mem_wdata      = mem_wr ? merged : 32'h0;
    assign MemDataReg_out = mdr_q;

endmodule

// File: tb/tb_store_rmw_sequencer.sv
// Scoreboard bench: two sequencers (read latency 1 and 3) share stimulus;
// a reference model predicts timed memory/done/err events per instance.
module tb_store_rmw_sequencer;

    localparam int EV_RD = 0;
    localparam int EV_WR = 1;
    localparam int EV_DONE = 2;
    localparam int EV_ERR = 3;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  SScontrol = 2'b00;
    logic [31:0] addr = 32'h0;
    logic [31:0] B_output = 32'h0;
    logic [31:0] mem_addr [2];
    logic        mem_rd [2];
    logic        mem_wr [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic [31:0] mdr_out [2];
    logic        busy [2];
    logic        done [2];
    logic        err [2];

    store_rmw_sequencer #(.READ_LATENCY(1), .CNT_W(4)) dut_l1 (
        .clk(clk), .reset(reset), .start(start), .SScontrol(SScontrol),
        .addr(addr), .B_output(B_output), .mem_addr(mem_addr[0]),
        .mem_rd(mem_rd[0]), .mem_wr(mem_wr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0]), .MemDataReg_out(mdr_out[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0])
    );

    store_rmw_sequencer #(.READ_LATENCY(3), .CNT_W(4)) dut_l3 (
        .clk(clk), .reset(reset), .start(start), .SScontrol(SScontrol),
        .addr(addr), .B_output(B_output), .mem_addr(mem_addr[1]),
        .mem_rd(mem_rd[1]), .mem_wr(mem_wr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1]), .MemDataReg_out(mdr_out[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1])
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          mon_on = 1'b0;
    logic [31:0] mem [16];
    logic [31:0] mdr_m [2];
    int          bf [2];
    int          bu [2];
    int          cd [2];
    logic [31:0] rda [2];
    ev_t         q0[$];
    ev_t         q1[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Memory: read data is valid only in the cycle READ_LATENCY after mem_rd
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_rd[k]) begin
                cd[k] = lat(k) - 1;
                rda[k] = mem_addr[k];
            end else if (cd[k] >= 0) begin
                cd[k] = cd[k] - 1;
            end
            mem_rdata[k] <= (cd[k] == 0) ? mem[rda[k][5:2]] : $urandom;
        end
    end

    task automatic chk(input string nm, input int k,
                       input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)",
                     nm, k, got, exp, cyc);
        end
    endtask

    function automatic ev_t mk(input int kind, input int c,
                               input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = kind;
        e.cyc = c;
        e.a = a;
        e.d = d;
        return e;
    endfunction

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push(input int k, input ev_t e);
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic pop(input int k, output ev_t e);
        if (k == 0) e = q0.pop_front();
        else e = q1.pop_front();
    endtask

    function automatic ev_t front(input int k);
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    task automatic take(input int k, input int kind, output ev_t e,
                        output bit ok);
        ok = 1'b0;
        e = mk(-1, -1, 32'h0, 32'h0);
        if (qsize(k) == 0) begin
            chk("unexpected_event", k, 32'(kind), 32'hFFFFFFFF);
        end else begin
            pop(k, e);
            chk("event_kind", k, 32'(kind), 32'(e.kind));
            chk("event_cycle", k, 32'(cyc), 32'(e.cyc));
            ok = 1'b1;
        end
    endtask

    task automatic mon(input int k);
        ev_t e;
        bit  ok;
        while (qsize(k) > 0 && front(k).cyc < cyc) begin
            pop(k, e);
            chk("missed_event", k, 32'(cyc), 32'(e.cyc));
        end
        chk("busy", k, 32'(busy[k]), 32'(cyc >= bf[k] && cyc <= bu[k]));
        if (mem_rd[k] && mem_wr[k])
            chk("rd_wr_overlap", k, 32'h1, 32'h0);
        if (mem_rd[k]) begin
            take(k, EV_RD, e, ok);
            if (ok) chk("rd_addr", k, mem_addr[k], e.a);
        end
        if (mem_wr[k]) begin
            take(k, EV_WR, e, ok);
            if (ok) begin
                chk("wr_addr", k, mem_addr[k], e.a);
                chk("wr_data", k, mem_wdata[k], e.d);
            end
        end
        if (done[k]) begin
            take(k, EV_DONE, e, ok);
            if (ok) chk("mdr_at_done", k, mdr_out[k], e.d);
        end
        if (err[k]) begin
            take(k, EV_ERR, e, ok);
            if (ok) chk("mdr_at_err", k, mdr_out[k], e.d);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on)
            for (int k = 0; k < 2; k++) mon(k);
    end

    function automatic logic [31:0] merge(input logic [1:0] op,
                                          input logic [31:0] old,
                                          input logic [31:0] b);
        if (op == 2'b10) return (old & 32'hFFFF0000) | (b & 32'h0000FFFF);
        if (op == 2'b11) return (old & 32'hFFFFFF00) | (b & 32'h000000FF);
        return b;
    endfunction

    function automatic bit is_err(input logic [1:0] op, input logic [31:0] a);
        return (op == 2'b01 && (a % 4) != 0) || (op == 2'b10 && (a % 2) != 0);
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        int t0;
        int l;
        logic [31:0] w;
        t0 = cyc;
        start = 1'b1;
        SScontrol = op;
        addr = a;
        B_output = b;
        for (int k = 0; k < 2; k++) begin
            l = lat(k);
            bf[k] = 1;
            bu[k] = 0;
            if (is_err(op, a)) begin
                push(k, mk(EV_ERR, t0 + 1, 32'h0, mdr_m[k]));
            end else if (op == 2'b00) begin
                push(k, mk(EV_DONE, t0 + 1, 32'h0, mdr_m[k]));
            end else if (op == 2'b01) begin
                push(k, mk(EV_WR, t0 + 1, a, b));
                push(k, mk(EV_DONE, t0 + 2, 32'h0, mdr_m[k]));
                bf[k] = t0 + 1;
                bu[k] = t0 + 1;
            end else begin
                w = mem[a[5:2]];
                mdr_m[k] = w;
                push(k, mk(EV_RD, t0 + 1, a, 32'h0));
                push(k, mk(EV_WR, t0 + 2 + l, a, merge(op, w, b)));
                push(k, mk(EV_DONE, t0 + 3 + l, 32'h0, w));
                bf[k] = t0 + 1;
                bu[k] = t0 + 2 + l;
            end
        end
        step();
        start = 1'b0;
        SScontrol = 2'($urandom);
        addr = $urandom;
        B_output = $urandom;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80 && (q0.size() + q1.size()) > 0; i++) step();
        if ((q0.size() + q1.size()) > 0) begin
            chk("drain_timeout", 0, 32'(q0.size() + q1.size()), 32'h0);
            q0.delete();
            q1.delete();
        end
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        for (int k = 0; k < 2; k++) begin
            mdr_m[k] = 32'h0;
            bf[k] = 1;
            bu[k] = 0;
            cd[k] = -1;
            rda[k] = 32'h0;
        end
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[8] = 32'h11223344;

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_mem_addr", k, mem_addr[k], 32'h0);
            chk("rst_mem_wdata", k, mem_wdata[k], 32'h0);
            chk("rst_mdr", k, mdr_out[k], 32'h0);
            chk("rst_strobes", k,
                {28'h0, mem_rd[k], mem_wr[k], done[k], err[k]}, 32'h0);
            chk("rst_busy", k, 32'(busy[k]), 32'h0);
        end
        step();
        reset = 1'b0;
        mon_on = 1'b1;
        step();

        issue(2'b01, 32'h10, 32'hDEADBEEF);
        wait_idle();
        issue(2'b10, 32'h20, 32'hAAAA5566);
        wait_idle();
        issue(2'b11, 32'h20, 32'hFFFFFF99);
        wait_idle();
        issue(2'b01, 32'h22, 32'h01020304);
        wait_idle();
        issue(2'b10, 32'h21, 32'h05060708);
        wait_idle();
        issue(2'b10, 32'h22, 32'h0000BEEF);
        wait_idle();
        issue(2'b00, 32'h07, 32'h12345678);
        wait_idle();

        // second start while busy, with changed operands, must be ignored
        issue(2'b11, 32'h2C, 32'hCAFE00A5);
        start = 1'b1;
        SScontrol = 2'b01;
        addr = 32'h30;
        B_output = 32'h0;
        step();
        start = 1'b0;
        wait_idle();

        // reset while the latency-3 instance sits in WAIT
        issue(2'b10, 32'h24, 32'h00001234);
        step();
        reset = 1'b1;
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            bu[k] = cyc;
            mdr_m[k] = 32'h0;
        end
        step();
        reset = 1'b0;
        repeat (3) step();
        issue(2'b01, 32'h3C, 32'h55AA55AA);
        wait_idle();

        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 3)) begin
                SScontrol = 2'($urandom);
                addr = $urandom;
                B_output = $urandom;
                step();
            end
            op = 2'($urandom);
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) a = a & 32'hFFFFFFFC;
            issue(op, a, $urandom);
            if (op[1] && !is_err(op, a) && $urandom_range(0, 3) == 0) begin
                start = 1'b1;
                SScontrol = 2'($urandom);
                step();
                start = 1'b0;
            end
            wait_idle();
        end

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_rmw_sequencer.md
Name: store_rmw_sequencer

Overview:
- Multicycle memory-store sequencer for the MIPS datapath.
- For sh/sb it reads the target word, captures it in its internal memory data register (MDR), merges the new low half/byte, and writes the word back.
- For sw it writes directly.
- It feeds the merge stage (exports the MDR value) and consumes the merged word as its write data; the merge is done internally with the same rule: sw = B, sh = {MDR[31:16], B[15:0]}, sb = {MDR[31:8], B[7:0]}.

Parameters:
- READ_LATENCY, 1, cycles from mem_rd asserted to mem_rdata valid. Legal values ≥1.
- CNT_W, 4, width of the latency counter. Must satisfy 2^CNT_W > READ_LATENCY.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- SScontrol  in  2  store size: 01 sw, 10 sh, 11 sb, 00 nop.
- addr  in  32  word byte-address of the store.
- B_output  in  32  store data from register B.
- mem_addr  out  32  memory address.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_wdata  out  32  merged write word.
- mem_rdata  in  32  memory read data.
- MemDataReg_out  out  32  MDR contents (last captured read word).
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle misalignment pulse.

Behaviour:
- Reset: state = IDLE, MDR = 0, latched op/addr/data = 0, latency counter = 0. All outputs are 0 (mem_addr = 0, mem_wdata = 0).
- Outputs are decoded from registered state (Moore); the MDR and latched operands are registers.
- States: IDLE, READ, WAIT, CAPTURE, WRITE, DONE, ERR.
- IDLE, start = 1: latch SScontrol, addr and B_output, then branch:
  - misaligned (sw with addr[1:0] != 0, or sh with addr[0] != 0): go to ERR;
  - op 00: go to DONE;
  - sw: go to WRITE;
  - sh/sb: go to READ.
- IDLE, start = 0: stay in IDLE.
- READ: mem_rd = 1, mem_addr = latched addr, counter loaded with READ_LATENCY-1. Next state is CAPTURE if READ_LATENCY == 1, else WAIT.
- WAIT: mem_rd = 0, mem_addr held. Counter decrements each cycle; go to CAPTURE when counter == 1.
- CAPTURE: MDR <= mem_rdata at the clock edge ending this state. Next state is WRITE.
- WRITE: mem_wr = 1, mem_addr = latched addr, mem_wdata = merge(op, MDR, latched B). For sw, MDR is not used and not modified. Next state is DONE.
- DONE: done = 1 for exactly one cycle, then IDLE.
- ERR: err = 1 for exactly one cycle, then IDLE. No mem_rd or mem_wr is ever asserted for an ERR request.
- busy = 1 in READ, WAIT, CAPTURE and WRITE; busy = 0 in IDLE, DONE and ERR.
- start in any state other than IDLE is ignored; nothing is queued.
- Latency with start at cycle T0:
  - sw: mem_wr at T1, done at T2.
  - sh/sb: mem_rd at T1, mem_rdata valid at T1+READ_LATENCY (CAPTURE state), mem_wr at T2+READ_LATENCY, done at T3+READ_LATENCY.
- Changes to inputs after the start cycle have no effect, because operands are latched.
- mem_rd and mem_wr are never asserted in the same cycle.
- MemDataReg_out holds its value until the next CAPTURE.
- Reset mid-operation (any state): return to IDLE on that edge with all strobes 0 from the next cycle. An interrupted request produces no write, no done and no err.
- Reset has priority over start in the same cycle.

Test Plan:
- Reset, then sw with addr = 0x10, B = 0xDEADBEEF → mem_wr = 1 at T1 with mem_addr = 0x10 and mem_wdata = 0xDEADBEEF; done at T2; mem_rd never asserted; MDR stays 0.
- Memory word at 0x20 = 0x11223344; sh with B = 0xAAAA5566, READ_LATENCY = 1 → mem_rd at T1, MDR = 0x11223344, mem_wr at T3 with wdata = 0x11225566, done at T4.
- Same memory word; sb with B = 0xFFFFFF99, READ_LATENCY = 3 → mem_wr at T5 with wdata = 0x11223399, done at T6; busy high T1..T5.
- sw at addr 0x22 and sh at addr 0x21 → err pulses at T1, no memory strobes, MDR unchanged; an sh at 0x22 is accepted normally.
- start pulsed while busy and SScontrol/B changed mid-operation → second request ignored; write uses the originally latched values.
- Reset asserted in the WAIT state → IDLE next cycle, no mem_wr, no done; a fresh sw started afterwards completes normally.
